// File: rtl/line_mem_arbiter_if.sv
// Line-side memory port (mem_itf) between a cache and the adaptor.
// The master issues address/read/write/wdata. The slave returns rdata/resp.
interface line_mem_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              resp;

    modport master (output address, read, write, wdata, input rdata, resp);
    modport slave  (input address, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/line_mem_arbiter.sv
// Shares one line port between the I-cache and the D-cache, serving one grant at a time.
// Fixed D-over-I priority by default; define LINE_ARB_RR_EN for round-robin.
module line_mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    line_mem_arbiter_if.slave  i_mem,
    line_mem_arbiter_if.slave  d_mem,
    line_mem_arbiter_if.master ca_mem
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_t;

    state_t            r_state;
    logic              w_i_pend;
    logic              w_d_pend;
    logic              w_pick_d;
    logic [ADDR_W-1:0] w_address;
    logic [LINE_W-1:0] w_wdata;
    logic              w_read;
    logic              w_write;
    logic              w_i_resp;
    logic              w_d_resp;
    logic [LINE_W-1:0] w_i_rdata;
    logic [LINE_W-1:0] w_d_rdata;

    assign w_i_pend = i_mem.read | i_mem.write;
    assign w_d_pend = d_mem.read | d_mem.write;

`ifdef LINE_ARB_RR_EN
    logic r_last_d;

    // On a tie, favour the requester that did not finish the previous grant
    always_comb begin
        if (w_i_pend && w_d_pend) begin
            w_pick_d = ~r_last_d;
        end else begin
            w_pick_d = w_d_pend;
        end
    end
`else
    assign w_pick_d = w_d_pend;
`endif

    // Grant FSM: every grant ends in IDLE so a finished requester never sees a stale grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
`ifdef LINE_ARB_RR_EN
            r_last_d <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_d) begin
                        r_state <= GRANT_D;
                    end else if (w_i_pend) begin
                        r_state <= GRANT_I;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GRANT_I: begin
                    if (ca_mem.resp) begin
                        r_state <= IDLE;
`ifdef LINE_ARB_RR_EN
                        r_last_d <= 1'b0;
`endif
                    end
                end
                GRANT_D: begin
                    if (ca_mem.resp) begin
                        r_state <= IDLE;
`ifdef LINE_ARB_RR_EN
                        r_last_d <= 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Forward the granted requester; read+write together goes out as a write
    always_comb begin
        w_address = '0;
        w_wdata   = '0;
        w_read    = 1'b0;
        w_write   = 1'b0;
        w_i_resp  = 1'b0;
        w_i_rdata = '0;
        w_d_resp  = 1'b0;
        w_d_rdata = '0;
        case (r_state)
            GRANT_I: begin
                w_address = i_mem.address;
                w_wdata   = i_mem.wdata;
                w_write   = i_mem.write;
                w_read    = i_mem.read & ~i_mem.write;
                w_i_resp  = ca_mem.resp;
                w_i_rdata = ca_mem.rdata;
            end
            GRANT_D: begin
                w_address = d_mem.address;
                w_wdata   = d_mem.wdata;
                w_write   = d_mem.write;
                w_read    = d_mem.read & ~d_mem.write;
                w_d_resp  = ca_mem.resp;
                w_d_rdata = ca_mem.rdata;
            end
            default: begin
                w_address = '0;
                w_wdata   = '0;
                w_read    = 1'b0;
                w_write   = 1'b0;
            end
        endcase
    end

    assign ca_mem.address = w_address;
    assign ca_mem.wdata   = w_wdata;
    assign ca_mem.read    = w_read;
    assign ca_mem.write   = w_write;
    assign i_mem.resp     = w_i_resp;
    assign i_mem.rdata    = w_i_rdata;
    assign d_mem.resp     = w_d_resp;
    assign d_mem.rdata    = w_d_rdata;
endmodule
